bsg_mcl_word_packer: RTL and testbench

BSG_MCL_WORD_PACKER -- requirements
Module: bsg_mcl_word_packer

---
 rtl/bsg_manycore_link_to_axil_pkg.sv | 18 +
 rtl/bsg_mcl_word_unpacker.sv | 52 +++++
 rtl/bsg_mcl_word_packer.sv | 91 +++++++++
 tb/tb_bsg_mcl_word_packer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_link_to_axil_pkg.sv
// Shared width constants and helpers for the manycore-link to AXI-Lite bridge.
// Both the word packer and the endpoint-to-FIFO adapter import this package.
package bsg_manycore_link_to_axil_pkg;

  localparam int host_width_gp = 32;
  localparam int fifo_width_gp = 128;

  // Number of host words that make up one FIFO packet.
  function automatic int words_f(input int fifo_width, input int host_width);
    return fifo_width / host_width;
  endfunction

  typedef enum logic {
    e_tx_fill,
    e_tx_full
  } tx_state_e;

endpackage

// File: rtl/bsg_mcl_word_unpacker.sv
// RX side: holds one packet and hands it to the host one word at a time,
// least-significant word first.
module bsg_mcl_word_unpacker
  import bsg_manycore_link_to_axil_pkg::*;
#(
  parameter int host_width_p = host_width_gp,
  parameter int fifo_width_p = fifo_width_gp,
  parameter int words_lp     = words_f(fifo_width_gp, host_width_gp),
  parameter int cnt_w_lp     = $clog2(words_lp + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    pkt_v_i,
  input  logic [fifo_width_p-1:0] pkt_data_i,
  output logic                    pkt_ready_o,
  output logic                    host_v_o,
  output logic [host_width_p-1:0] host_data_o,
  input  logic                    host_yumi_i,
  output logic [cnt_w_lp-1:0]     rx_words_o
);

  logic [fifo_width_p-1:0] rx_data_r;
  logic [cnt_w_lp-1:0]     rx_cnt_r;

  assign pkt_ready_o = (rx_cnt_r == '0);
  assign host_v_o    = (rx_cnt_r != '0);
  assign rx_words_o  = rx_cnt_r;

  // Load only when empty; a yumi while empty is ignored so the count never wraps.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_data_r <= '0;
      rx_cnt_r  <= '0;
    end else if (pkt_v_i && pkt_ready_o) begin
      rx_data_r <= pkt_data_i;
      rx_cnt_r  <= cnt_w_lp'(words_lp);
    end else if (host_yumi_i && host_v_o) begin
      rx_cnt_r  <= rx_cnt_r - cnt_w_lp'(1);
    end
  end

  // Remaining count maps to slice index words_lp - rx_cnt; zero when empty.
  always_comb begin
    host_data_o = '0;
    for (int i = 0; i < words_lp; i++) begin
      if (rx_cnt_r == cnt_w_lp'(words_lp - i)) begin
        host_data_o = rx_data_r[i*host_width_p +: host_width_p];
      end
    end
  end

endmodule

// File: rtl/bsg_mcl_word_packer.sv
// Host-word <-> FIFO-packet width converter: TX packs host words into one
// packet, RX unpacks one packet into host words. One packet of buffering each way.
module bsg_mcl_word_packer
  import bsg_manycore_link_to_axil_pkg::*;
#(
  parameter int host_width_p = host_width_gp,
  parameter int fifo_width_p = fifo_width_gp
) (
  input  logic                                                       clk_i,
  input  logic                                                       reset_i,
  input  logic                                                       host_v_i,
  input  logic [host_width_p-1:0]                                    host_data_i,
  output logic                                                       host_ready_o,
  output logic                                                       pkt_v_o,
  output logic [fifo_width_p-1:0]                                    pkt_data_o,
  input  logic                                                       pkt_ready_i,
  input  logic                                                       pkt_v_i,
  input  logic [fifo_width_p-1:0]                                    pkt_data_i,
  output logic                                                       pkt_ready_o,
  output logic                                                       host_v_o,
  output logic [host_width_p-1:0]                                    host_data_o,
  input  logic                                                       host_yumi_i,
  output logic [$clog2(words_f(fifo_width_p, host_width_p)+1)-1:0]   tx_words_o,
  output logic [$clog2(words_f(fifo_width_p, host_width_p)+1)-1:0]   rx_words_o
);

  localparam int words_lp = words_f(fifo_width_p, host_width_p);
  localparam int cnt_w_lp = $clog2(words_lp + 1);

  if ((fifo_width_p % host_width_p) != 0 || fifo_width_p < host_width_p) begin : g_bad_width
    $error("bsg_mcl_word_packer: fifo_width_p must be a multiple of host_width_p");
  end

  tx_state_e               tx_state_r;
  logic [cnt_w_lp-1:0]     tx_cnt_r;
  logic [fifo_width_p-1:0] tx_data_r;

  assign host_ready_o = (tx_state_r == e_tx_fill);
  assign pkt_v_o      = (tx_state_r == e_tx_full);
  assign pkt_data_o   = tx_data_r;
  assign tx_words_o   = tx_cnt_r;

  // State tracks tx_cnt == words_lp so ready/valid come straight from a flop.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tx_state_r <= e_tx_fill;
      tx_cnt_r   <= '0;
      tx_data_r  <= '0;
    end else begin
      case (tx_state_r)
        e_tx_fill: begin
          if (host_v_i) begin
            for (int i = 0; i < words_lp; i++) begin
              if (tx_cnt_r == cnt_w_lp'(i)) begin
                tx_data_r[i*host_width_p +: host_width_p] <= host_data_i;
              end
            end
            tx_cnt_r <= tx_cnt_r + cnt_w_lp'(1);
            if (tx_cnt_r == cnt_w_lp'(words_lp - 1)) begin
              tx_state_r <= e_tx_full;
            end
          end
        end
        e_tx_full: begin
          if (pkt_ready_i) begin
            tx_cnt_r   <= '0;
            tx_state_r <= e_tx_fill;
          end
        end
      endcase
    end
  end

  bsg_mcl_word_unpacker #(
    .host_width_p (host_width_p),
    .fifo_width_p (fifo_width_p),
    .words_lp     (words_lp),
    .cnt_w_lp     (cnt_w_lp)
  ) unpacker (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .pkt_v_i     (pkt_v_i),
    .pkt_data_i  (pkt_data_i),
    .pkt_ready_o (pkt_ready_o),
    .host_v_o    (host_v_o),
    .host_data_o (host_data_o),
    .host_yumi_i (host_yumi_i),
    .rx_words_o  (rx_words_o)
  );

endmodule

// File: tb/tb_bsg_mcl_word_packer.sv
// Directed and random checks of the word packer; expected packets and words
// are queued when driven and compared when the DUT presents them.
module tb_bsg_mcl_word_packer;

  localparam int hw          = 32;
  localparam int fw          = 128;
  localparam int words       = 4;
  localparam int n_pkts      = 1000;
  localparam int cycle_limit = 40000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          host_v_i = 1'b0;
  logic [hw-1:0] host_data_i = '0;
  logic          host_ready_o;
  logic          pkt_v_o;
  logic [fw-1:0] pkt_data_o;
  logic          pkt_ready_i = 1'b0;
  logic          pkt_v_i = 1'b0;
  logic [fw-1:0] pkt_data_i = '0;
  logic          pkt_ready_o;
  logic          host_v_o;
  logic [hw-1:0] host_data_o;
  logic          host_yumi_i = 1'b0;
  logic [2:0]    tx_words_o;
  logic [2:0]    rx_words_o;

  int total = 0;
  int bad   = 0;

  logic [hw-1:0] tx_q[$];
  logic [hw-1:0] rx_q[$];
  logic [fw-1:0] pkt_exp_q[$];

  bsg_mcl_word_packer dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .host_v_i     (host_v_i),
    .host_data_i  (host_data_i),
    .host_ready_o (host_ready_o),
    .pkt_v_o      (pkt_v_o),
    .pkt_data_o   (pkt_data_o),
    .pkt_ready_i  (pkt_ready_i),
    .pkt_v_i      (pkt_v_i),
    .pkt_data_i   (pkt_data_i),
    .pkt_ready_o  (pkt_ready_o),
    .host_v_o     (host_v_o),
    .host_data_o  (host_data_o),
    .host_yumi_i  (host_yumi_i),
    .tx_words_o   (tx_words_o),
    .rx_words_o   (rx_words_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [fw-1:0] observed, input logic [fw-1:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_host_ready"}, fw'(host_ready_o), fw'(1));
    check_output({tag, "_pkt_ready"},  fw'(pkt_ready_o),  fw'(1));
    check_output({tag, "_pkt_v"},      fw'(pkt_v_o),      fw'(0));
    check_output({tag, "_host_v"},     fw'(host_v_o),     fw'(0));
    check_output({tag, "_pkt_data"},   pkt_data_o,        fw'(0));
    check_output({tag, "_host_data"},  fw'(host_data_o),  fw'(0));
    check_output({tag, "_tx_words"},   fw'(tx_words_o),   fw'(0));
    check_output({tag, "_rx_words"},   fw'(rx_words_o),   fw'(0));
  endtask

  // Offers one host word for one cycle; the packer must be ready for it.
  task automatic apply_stimulus(input logic [hw-1:0] word);
    host_v_i    = 1'b1;
    host_data_i = word;
    check_output("host_ready_before_word", fw'(host_ready_o), fw'(1));
    tick();
    host_v_i = 1'b0;
  endtask

  task automatic check_pkt(input string tag);
    check_output({tag, "_expected_present"}, fw'(pkt_exp_q.size() != 0), fw'(1));
    if (pkt_exp_q.size() != 0) check_output(tag, pkt_data_o, pkt_exp_q.pop_front());
  endtask

  initial begin
    logic [fw-1:0] held;

    // Reset held across an edge.
    tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    check_reset_outputs("after_reset");

    // Back-to-back TX packet.
    pkt_ready_i = 1'b1;
    pkt_exp_q.push_back(128'h44444444_33333333_22222222_11111111);
    apply_stimulus(32'h11111111);
    check_output("tx_words_1", fw'(tx_words_o), fw'(1));
    apply_stimulus(32'h22222222);
    apply_stimulus(32'h33333333);
    apply_stimulus(32'h44444444);
    check_output("tx_full_pkt_v", fw'(pkt_v_o), fw'(1));
    check_output("tx_full_host_ready", fw'(host_ready_o), fw'(0));
    check_output("tx_full_words", fw'(tx_words_o), fw'(4));
    check_pkt("tx_pkt_data");
    tick();
    check_output("tx_sent_pkt_v", fw'(pkt_v_o), fw'(0));
    check_output("tx_sent_host_ready", fw'(host_ready_o), fw'(1));
    check_output("tx_sent_words", fw'(tx_words_o), fw'(0));

    // TX backpressure with a fifth word waiting.
    pkt_ready_i = 1'b0;
    held = 128'h88888888_77777777_66666666_55555555;
    pkt_exp_q.push_back(held);
    apply_stimulus(32'h55555555);
    apply_stimulus(32'h66666666);
    apply_stimulus(32'h77777777);
    apply_stimulus(32'h88888888);
    host_v_i    = 1'b1;
    host_data_i = 32'h99999999;
    for (int i = 0; i < 10; i++) begin
      check_output("bp_pkt_v", fw'(pkt_v_o), fw'(1));
      check_output("bp_pkt_data", pkt_data_o, held);
      check_output("bp_host_ready", fw'(host_ready_o), fw'(0));
      check_output("bp_tx_words", fw'(tx_words_o), fw'(4));
      tick();
    end
    pkt_ready_i = 1'b1;
    check_pkt("bp_pkt_release");
    tick();
    check_output("bp_release_pkt_v", fw'(pkt_v_o), fw'(0));
    check_output("bp_release_tx_words", fw'(tx_words_o), fw'(0));
    check_output("bp_release_host_ready", fw'(host_ready_o), fw'(1));
    tick();
    host_v_i = 1'b0;
    check_output("bp_fifth_word_taken", fw'(tx_words_o), fw'(1));
    pkt_exp_q.push_back(128'hCCCCCCCC_BBBBBBBB_AAAAAAAA_99999999);
    apply_stimulus(32'hAAAAAAAA);
    apply_stimulus(32'hBBBBBBBB);
    apply_stimulus(32'hCCCCCCCC);
    check_output("bp_second_pkt_v", fw'(pkt_v_o), fw'(1));
    check_pkt("bp_second_pkt");
    tick();
    check_output("bp_second_sent", fw'(pkt_v_o), fw'(0));

    // RX unpack with yumi every cycle.
    pkt_v_i    = 1'b1;
    pkt_data_i = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    check_output("rx_pkt_ready_idle", fw'(pkt_ready_o), fw'(1));
    tick();
    pkt_v_i = 1'b0;
    check_output("rx_pkt_ready_loaded", fw'(pkt_ready_o), fw'(0));
    rx_q.push_back(32'hAAAAAAAA);
    rx_q.push_back(32'hBBBBBBBB);
    rx_q.push_back(32'hCCCCCCCC);
    rx_q.push_back(32'hDDDDDDDD);
    host_yumi_i = 1'b1;
    for (int i = 0; i < words; i++) begin
      check_output("rx_host_v", fw'(host_v_o), fw'(1));
      check_output("rx_words", fw'(rx_words_o), fw'(words - i));
      check_output("rx_host_data", fw'(host_data_o), fw'(rx_q.pop_front()));
      tick();
    end
    check_output("rx_drained_pkt_ready", fw'(pkt_ready_o), fw'(1));
    check_output("rx_drained_host_v", fw'(host_v_o), fw'(0));

    // Spurious yumi while empty.
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("spurious_rx_words", fw'(rx_words_o), fw'(0));
      check_output("spurious_host_v", fw'(host_v_o), fw'(0));
      check_output("spurious_pkt_ready", fw'(pkt_ready_o), fw'(1));
    end
    host_yumi_i = 1'b0;

    // Reset mid-packet on both paths.
    host_v_i    = 1'b1;
    host_data_i = 32'hE1E1E1E1;
    pkt_v_i     = 1'b1;
    pkt_data_i  = 128'h04040404_03030303_02020202_01010101;
    tick();
    host_data_i = 32'hE2E2E2E2;
    pkt_v_i     = 1'b0;
    host_yumi_i = 1'b1;
    tick();
    host_v_i    = 1'b0;
    host_yumi_i = 1'b0;
    check_output("mid_tx_words", fw'(tx_words_o), fw'(2));
    check_output("mid_rx_words", fw'(rx_words_o), fw'(3));
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    tick();
    reset = 1'b0;
    check_reset_outputs("post_async_reset");
    pkt_exp_q.push_back(128'hF4F4F4F4_F3F3F3F3_F2F2F2F2_F1F1F1F1);
    apply_stimulus(32'hF1F1F1F1);
    apply_stimulus(32'hF2F2F2F2);
    apply_stimulus(32'hF3F3F3F3);
    apply_stimulus(32'hF4F4F4F4);
    check_output("fresh_pkt_v", fw'(pkt_v_o), fw'(1));
    check_pkt("fresh_pkt");
    tick();
    check_output("fresh_sent", fw'(pkt_v_o), fw'(0));
    check_output("fresh_no_rx", fw'(host_v_o), fw'(0));

    // Concurrent random traffic on both paths.
    $display("[TB] random traffic: %0d packets each way", n_pkts);
    fork
      begin : tx_producer
        int sent = 0;
        int cyc  = 0;
        while (sent < n_pkts * words && cyc < cycle_limit) begin
          tick();
          cyc++;
          host_v_i    = ($urandom_range(0, 3) != 0);
          host_data_i = $urandom();
          if (host_v_i && host_ready_o) begin
            tx_q.push_back(host_data_i);
            sent++;
          end
        end
        tick();
        host_v_i = 1'b0;
        if (sent < n_pkts * words) check_output("tx_producer_timeout", fw'(sent), fw'(n_pkts * words));
      end
      begin : tx_consumer
        int got = 0;
        int cyc = 0;
        logic [fw-1:0] exp_pkt;
        while (got < n_pkts && cyc < cycle_limit) begin
          tick();
          cyc++;
          pkt_ready_i = ($urandom_range(0, 1) == 1);
          if (pkt_v_o && pkt_ready_i) begin
            check_output("rand_tx_words_queued", fw'(tx_q.size() >= words), fw'(1));
            if (tx_q.size() >= words) begin
              exp_pkt = {tx_q[3], tx_q[2], tx_q[1], tx_q[0]};
              repeat (words) void'(tx_q.pop_front());
              check_output("rand_tx_pkt", pkt_data_o, exp_pkt);
            end
            got++;
          end
        end
        tick();
        pkt_ready_i = 1'b0;
        if (got < n_pkts) check_output("tx_consumer_timeout", fw'(got), fw'(n_pkts));
      end
      begin : rx_producer
        int sent = 0;
        int cyc  = 0;
        while (sent < n_pkts && cyc < cycle_limit) begin
          tick();
          cyc++;
          pkt_v_i    = ($urandom_range(0, 1) == 1);
          pkt_data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
          if (pkt_v_i && pkt_ready_o) begin
            for (int i = 0; i < words; i++) rx_q.push_back(pkt_data_i[i*hw +: hw]);
            sent++;
          end
        end
        tick();
        pkt_v_i = 1'b0;
        if (sent < n_pkts) check_output("rx_producer_timeout", fw'(sent), fw'(n_pkts));
      end
      begin : rx_consumer
        int got = 0;
        int cyc = 0;
        while (got < n_pkts * words && cyc < cycle_limit) begin
          tick();
          cyc++;
          host_yumi_i = ($urandom_range(0, 1) == 1);
          if (host_v_o && host_yumi_i) begin
            check_output("rand_rx_word_queued", fw'(rx_q.size() != 0), fw'(1));
            if (rx_q.size() != 0) check_output("rand_rx_word", fw'(host_data_o), fw'(rx_q.pop_front()));
            got++;
          end
        end
        tick();
        host_yumi_i = 1'b0;
        if (got < n_pkts * words) check_output("rx_consumer_timeout", fw'(got), fw'(n_pkts * words));
      end
    join

    check_output("rand_tx_leftover", fw'(tx_q.size()), fw'(0));
    check_output("rand_rx_leftover", fw'(rx_q.size()), fw'(0));
    check_output("rand_end_tx_words", fw'(tx_words_o), fw'(0));
    check_output("rand_end_rx_words", fw'(rx_words_o), fw'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
